// File: rtl/sctrl_pkg.sv
// Shared types and constants for the sensor-control capture path.
package sctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_FULL    = 2'd2
  } sctrl_state_e;

  localparam int SCTRL_DEPTH  = 64;
  localparam int SCTRL_DATA_W = 32;
  localparam int SCTRL_ADDR_W = $clog2(SCTRL_DEPTH);

  // Register addresses decoded by the AXI slave wrapper above this core.
  localparam logic [31:0] SCTRL_EN_ADDR  = 32'h1000_0100;
  localparam logic [31:0] SCTRL_CLR_ADDR = 32'h1000_0200;

endpackage

// File: rtl/sctrl_sample_mem.sv
// Sample buffer: DEPTH x DATA_W flops, one synchronous write port,
// one combinational read port. Everything resets to zero.
module sctrl_sample_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [31:0]       w_raddr_ext;

  assign w_raddr_ext = 32'(i_raddr);

  // Storage: cleared on reset, written one word per cycle when enabled.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Zero-latency read; a write in progress is only visible after the edge.
  always_comb begin
    o_rdata = '0;
    if (w_raddr_ext < 32'(DEPTH)) begin
      o_rdata = r_mem[i_raddr];
    end else begin
      o_rdata = '0;
    end
  end

endmodule

// File: rtl/sensor_capture_core.sv
// Sensor capture engine: sequences the sensor handshake, fills the sample
// buffer linearly from address 0 and flags an interrupt once it is full.
module sensor_capture_core
  import sctrl_pkg::*;
#(
  parameter int DATA_W = SCTRL_DATA_W,
  parameter int DEPTH  = SCTRL_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              sctrl_en,
  input  logic              sctrl_clear,
  input  logic [ADDR_W-1:0] sctrl_addr,
  input  logic              sensor_ready,
  input  logic [DATA_W-1:0] sensor_out,
  output logic              sensor_en,
  output logic              sctrl_interrupt,
  output logic [DATA_W-1:0] sctrl_out,
  output logic [ADDR_W:0]   fill_level
);

  // Pointer value of the last buffer slot; writing it completes the buffer.
  localparam logic [ADDR_W:0] LP_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] LP_ONE  = (ADDR_W + 1)'(1);

  sctrl_state_e    r_state;
  logic [ADDR_W:0] r_wr_ptr;
  logic            r_sensor_en;
  logic            r_interrupt;
  logic            w_wr_en;
  logic            w_last;

  // A sample is accepted only while actively capturing; clear drops it, and
  // the pointer MSB blocks any write once the buffer is complete.
  assign w_wr_en = (r_state == S_CAPTURE) && r_sensor_en && sensor_ready &&
                   !sctrl_clear && !r_wr_ptr[ADDR_W];
  assign w_last  = (r_wr_ptr == LP_LAST);

  // Control FSM with write pointer, sensor request and interrupt registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_sensor_en <= 1'b0;
      r_interrupt <= 1'b0;
    end else if (sctrl_clear) begin
      r_wr_ptr    <= '0;
      r_interrupt <= 1'b0;
      if (sctrl_en) begin
        r_state     <= S_CAPTURE;
        r_sensor_en <= 1'b1;
      end else begin
        r_state     <= S_IDLE;
        r_sensor_en <= 1'b0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_interrupt <= 1'b0;
          if (sctrl_en) begin
            r_state     <= S_CAPTURE;
            r_sensor_en <= 1'b1;
          end else begin
            r_sensor_en <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + LP_ONE;
          end
          // Completing the buffer outranks a pause request.
          if (w_wr_en && w_last) begin
            r_state     <= S_FULL;
            r_sensor_en <= 1'b0;
            r_interrupt <= 1'b1;
          end else if (!sctrl_en) begin
            // Pause: pointer is kept so capture resumes where it stopped.
            r_state     <= S_IDLE;
            r_sensor_en <= 1'b0;
          end else begin
            r_sensor_en <= 1'b1;
          end
        end
        S_FULL: begin
          r_sensor_en <= 1'b0;
          r_interrupt <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_sensor_en <= 1'b0;
          r_interrupt <= 1'b0;
        end
      endcase
    end
  end

  assign sensor_en       = r_sensor_en;
  assign sctrl_interrupt = r_interrupt;
  assign fill_level      = r_wr_ptr;

  sctrl_sample_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (sensor_out),
    .i_raddr (sctrl_addr),
    .o_rdata (sctrl_out)
  );

endmodule

// File: tb/tb_sensor_capture_core.sv
// Scoreboard bench for sensor_capture_core: a behavioural model predicts
// outputs just before and just after every clock edge; monitors compare.
module tb_sensor_capture_core;

  logic        ACLK;
  logic        ARESETn;
  logic        sctrl_en;
  logic        sctrl_clear;
  logic [5:0]  sctrl_addr;
  logic        sensor_ready;
  logic [31:0] sensor_out;
  logic        sensor_en;
  logic        sctrl_interrupt;
  logic [31:0] sctrl_out;
  logic [6:0]  fill_level;

  sensor_capture_core dut (
    .ACLK            (ACLK),
    .ARESETn         (ARESETn),
    .sctrl_en        (sctrl_en),
    .sctrl_clear     (sctrl_clear),
    .sctrl_addr      (sctrl_addr),
    .sensor_ready    (sensor_ready),
    .sensor_out      (sensor_out),
    .sensor_en       (sensor_en),
    .sctrl_interrupt (sctrl_interrupt),
    .sctrl_out       (sctrl_out),
    .fill_level      (fill_level)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic        en;
    logic        irq;
    logic [6:0]  fill;
    logic [31:0] rd;
    logic [5:0]  addr;
  } rec_t;

  rec_t q_pre[$];
  rec_t q_post[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // ---------------- behavioural reference model ----------------
  // m_mode: 0 = waiting, 1 = capturing, 2 = buffer complete
  int          m_mode;
  int          m_cnt;
  logic [31:0] m_mem [64];

  task automatic m_reset();
    m_mode = 0;
    m_cnt  = 0;
    for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
  endtask

  task automatic m_step(input bit en, input bit clr, input bit rdy, input logic [31:0] dat);
    if (m_mode == 1 && rdy && !clr && m_cnt < 64) begin
      m_mem[m_cnt] = dat;
      m_cnt = m_cnt + 1;
    end
    if (clr) begin
      m_cnt  = 0;
      m_mode = en ? 1 : 0;
    end else if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_cnt == 64) m_mode = 2;
      else if (!en) m_mode = 0;
    end
  endtask

  function automatic rec_t mk(input logic [5:0] a);
    rec_t r;
    r.en   = (m_mode == 1);
    r.irq  = (m_mode == 2);
    r.fill = 7'(m_cnt);
    r.rd   = m_mem[a];
    r.addr = a;
    return r;
  endfunction

  // ---------------- comparison ----------------
  task automatic chk(input string ph, input rec_t e);
    n_checks++;
    if (sensor_en !== e.en) begin
      n_err++;
      $display("FAIL %s sensor_en t=%0t: got %0b expected %0b", ph, $time, sensor_en, e.en);
    end
    n_checks++;
    if (sctrl_interrupt !== e.irq) begin
      n_err++;
      $display("FAIL %s interrupt t=%0t: got %0b expected %0b", ph, $time, sctrl_interrupt, e.irq);
    end
    n_checks++;
    if (fill_level !== e.fill) begin
      n_err++;
      $display("FAIL %s fill_level t=%0t: got %0d expected %0d", ph, $time, fill_level, e.fill);
    end
    n_checks++;
    if (sctrl_out !== e.rd) begin
      n_err++;
      $display("FAIL %s read[%0d] t=%0t: got %h expected %h", ph, e.addr, $time, sctrl_out, e.rd);
    end
  endtask

  // Monitor: state just before the next edge (inputs already applied).
  always begin
    rec_t e;
    @(negedge ACLK);
    #3;
    if (q_pre.size() > 0) begin
      e = q_pre.pop_front();
      chk("pre", e);
    end
  end

  // Monitor: state just after the edge.
  always begin
    rec_t e;
    @(posedge ACLK);
    #2;
    if (q_post.size() > 0) begin
      e = q_post.pop_front();
      chk("post", e);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rst, input bit en, input bit clr, input bit rdy,
                     input logic [31:0] dat, input logic [5:0] addr);
    @(negedge ACLK);
    ARESETn      = !rst;
    sctrl_en     = en;
    sctrl_clear  = clr;
    sensor_ready = rdy;
    sensor_out   = dat;
    sctrl_addr   = addr;
    if (rst) m_reset();
    q_pre.push_back(mk(addr));
    @(posedge ACLK);
    if (!rst) m_step(en, clr, rdy, dat);
    q_post.push_back(mk(addr));
  endtask

  // Keep capturing (random ready gaps) until the model holds 'target' samples.
  task automatic fill_to(input int target);
    int guard;
    guard = 0;
    while (m_cnt < target && guard < 500) begin
      cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom, 6'($urandom));
      guard++;
    end
    n_checks++;
    if (m_cnt < target) begin
      n_err++;
      $display("FAIL fill_to budget: got %0d expected %0d", m_cnt, target);
    end
  endtask

  task automatic sweep();
    for (int i = 0; i < 64; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'(i));
  endtask

  initial begin
    ARESETn = 1'b0; sctrl_en = 1'b0; sctrl_clear = 1'b0;
    sensor_ready = 1'b0; sensor_out = 32'h0; sctrl_addr = 6'd0;
    m_reset();

    // reset state
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 6'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 6'd7);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'd63);

    // 1: full capture of 0..63, then read everything back
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'd0);
    for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'(i), 6'($urandom));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'd63);
    sweep();

    // 2: ready ignored when full, then clear with enable high
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 6'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 6'd63);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 6'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'd2);

    // 3: capture 10, pause 5 cycles with ready pulsing, resume to full
    fill_to(10);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, $urandom, 6'($urandom));
    fill_to(64);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'd0);
    sweep();

    // 4: clear and ready together at fill_level 20
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 6'd0);
    fill_to(20);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA_5555, 6'd20);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D, 6'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'd20);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'd0);

    // 5: asynchronous reset mid-capture at fill_level 30
    fill_to(30);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, $urandom, 6'd3);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, $urandom, 6'd4);
    sweep();

    // 6: same-cycle read of the entry being written
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 6'd0);
    fill_to(5);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 6'd5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'd5);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 1)), $urandom, 6'($urandom));
    end

    // drain scoreboard
    for (int i = 0; i < 3; i++) @(posedge ACLK);
    n_checks++;
    if (q_pre.size() != 0 || q_post.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d pending expected 0", q_pre.size(), q_post.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
